// File: rtl/sample_seq_ctrl.sv
// Sample sequencer for the encoder: buffers one upstream sample, loads it into
// the input register, steps the datapath through PHASES compute phases, then presents the result.
module sample_seq_ctrl #(
  parameter int DW     = 8,
  parameter int PHASES = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          ld_en,
  output logic [DW-1:0] reg_data,
  output logic [4:0]    phase,
  output logic          phase_en,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic [15:0]   done_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [4:0] LAST_PHASE = 5'(PHASES - 1);

  state_t          state, state_nxt;
  logic            hold_full;
  logic [DW-1:0]   hold_data;
  logic [DW-1:0]   reg_q;
  logic [4:0]      phase_cnt;
  logic [15:0]     done_count;
  logic            accept;
  logic            start;
  logic            last_phase;
  logic            res_fire;

  assign s_ready    = !hold_full;
  assign accept     = s_valid && s_ready;
  assign start      = hold_full || accept;
  assign last_phase = (phase_cnt == LAST_PHASE);
  assign res_fire   = res_valid && res_ready;
  assign busy       = (state != IDLE);
  assign done_cnt   = done_count;

  // The input register sees the held sample during LOAD itself, then keeps it.
  assign reg_data   = (state == LOAD) ? hold_data : reg_q;
  assign phase      = phase_en ? phase_cnt : 5'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_en     = 1'b0;
    phase_en  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_en     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        phase_en = 1'b1;
        if (last_phase) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        // A sample accepted in this same cycle counts as start.
        if (res_ready) state_nxt = start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept is impossible in LOAD (buffer full), so set and clear never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= s_data;
    end else if (state == LOAD) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              reg_q <= '0;
    else if (state == LOAD) reg_q <= hold_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           phase_cnt <= 5'd0;
    else if (state == LOAD)              phase_cnt <= 5'd0;
    else if (state == RUN && !last_phase) phase_cnt <= phase_cnt + 5'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         done_count <= 16'd0;
    else if (res_fire) done_count <= done_count + 16'd1;
  end

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// Directed bench for sample_seq_ctrl: default build (PHASES=12) plus a PHASES=2 build.
module tb_sample_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid, s_ready, ld_en, phase_en, res_valid, res_ready, busy;
  logic [7:0]  s_data, reg_data;
  logic [4:0]  phase;
  logic [15:0] done_cnt;

  logic        s_valid2, s_ready2, ld_en2, phase_en2, res_valid2, res_ready2, busy2;
  logic [7:0]  s_data2, reg_data2;
  logic [4:0]  phase2;
  logic [15:0] done_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sample_seq_ctrl #(.DW(8), .PHASES(12)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ld_en(ld_en), .reg_data(reg_data), .phase(phase), .phase_en(phase_en),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done_cnt(done_cnt)
  );

  sample_seq_ctrl #(.DW(8), .PHASES(2)) u_p2 (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .ld_en(ld_en2), .reg_data(reg_data2), .phase(phase2), .phase_en(phase_en2),
    .res_valid(res_valid2), .res_ready(res_ready2), .busy(busy2), .done_cnt(done_cnt2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    s_valid = 1'b0; s_data = 8'h00; res_ready = 1'b0;
    s_valid2 = 1'b0; s_data2 = 8'h00; res_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_valid = 1'b1; s_data = 8'hFF; res_ready = 1'b1;
    s_valid2 = 1'b1; s_data2 = 8'hFF; res_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_held got rdy=%0b ld=%0b pe=%0b ph=%0d rv=%0b busy=%0b cnt=%h data=%h want 1 0 0 0 0 0 0000 00",
               s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data);
    end
    s_valid = 1'b0; s_valid2 = 1'b0; res_ready = 1'b0; res_ready2 = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_released got rdy=%0b ld=%0b pe=%0b ph=%0d rv=%0b busy=%0b cnt=%h data=%h want 1 0 0 0 0 0 0000 00",
               s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data);
    end
    tests++;
    if ({s_ready2, ld_en2, phase_en2, phase2, res_valid2, busy2, done_cnt2, reg_data2} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_p2 got rdy=%0b ld=%0b pe=%0b busy=%0b want 1 0 0 0", s_ready2, ld_en2, phase_en2, busy2);
    end
  endtask

  task automatic test_single;
    do_reset();
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge clk);
    tests++;
    if ({s_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL single_accept got rdy=%0b busy=%0b want 1 0", s_ready, busy);
    end
    step();
    s_valid = 1'b0; s_data = 8'h00;
    @(negedge clk);
    tests++;
    if ({ld_en, reg_data, phase_en, s_ready, busy} !== {1'b1, 8'h5A, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL single_load got ld=%0b data=%h pe=%0b rdy=%0b busy=%0b want 1 5a 0 0 1",
               ld_en, reg_data, phase_en, s_ready, busy);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if ({phase_en, phase, ld_en, res_valid, reg_data} !== {1'b1, 5'(i), 1'b0, 1'b0, 8'h5A}) begin
        fails++;
        $display("FAIL single_phase cycle %0d got pe=%0b ph=%0d ld=%0b rv=%0b data=%h want 1 %0d 0 0 5a",
                 i + 2, phase_en, phase, ld_en, res_valid, reg_data, i);
      end
      step();
    end
    @(negedge clk);
    tests++;
    if ({res_valid, phase_en, phase, busy} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      fails++;
      $display("FAIL single_result got rv=%0b pe=%0b ph=%0d busy=%0b want 1 0 0 1", res_valid, phase_en, phase, busy);
    end
    step();
    res_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({res_valid, done_cnt} !== {1'b1, 16'd0}) begin
      fails++;
      $display("FAIL single_result_held got rv=%0b cnt=%h want 1 0000", res_valid, done_cnt);
    end
    step();
    res_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, res_valid, done_cnt, reg_data, s_ready} !== {1'b0, 1'b0, 16'd1, 8'h5A, 1'b1}) begin
      fails++;
      $display("FAIL single_after got busy=%0b rv=%0b cnt=%h data=%h rdy=%0b want 0 0 0001 5a 1",
               busy, res_valid, done_cnt, reg_data, s_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic       ld_x, pe_x, rv_x, sr_x;
    logic [4:0] ph_x;
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h20 + c);
      ld_x = (c == 1) || (c == 15) || (c == 29);
      rv_x = (c == 14) || (c == 28);
      sr_x = (c == 0) || (c == 2) || (c == 16);
      pe_x = (c >= 2 && c <= 13) || (c >= 16 && c <= 27);
      ph_x = !pe_x ? 5'd0 : (c < 16) ? 5'(c - 2) : 5'(c - 16);
      @(negedge clk);
      tests++;
      if ({ld_en, phase_en, phase, res_valid, s_ready} !== {ld_x, pe_x, ph_x, rv_x, sr_x}) begin
        fails++;
        $display("FAIL b2b cycle %0d got ld=%0b pe=%0b ph=%0d rv=%0b rdy=%0b want %0b %0b %0d %0b %0b",
                 c, ld_en, phase_en, phase, res_valid, s_ready, ld_x, pe_x, ph_x, rv_x, sr_x);
      end
      if (ld_x) begin
        tests++;
        if (reg_data !== ((c == 1) ? 8'h20 : (c == 15) ? 8'h22 : 8'h30)) begin
          fails++;
          $display("FAIL b2b_data cycle %0d got %h want %h", c, reg_data,
                   (c == 1) ? 8'h20 : (c == 15) ? 8'h22 : 8'h30);
        end
      end
      if (c == 29) begin
        tests++;
        if (done_cnt !== 16'd2) begin
          fails++;
          $display("FAIL b2b_count got %0d want 2", done_cnt);
        end
      end
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      s_valid   = (c == 0) || (c >= 2 && c <= 33);
      s_data    = (c == 0) ? 8'hA1 : (c == 2) ? 8'hBB : 8'hCC;
      res_ready = (c >= 34);
      @(negedge clk);
      if (c >= 14 && c <= 34) begin
        tests++;
        if ({res_valid, s_ready, busy} !== 3'b101) begin
          fails++;
          $display("FAIL bp_stall cycle %0d got rv=%0b rdy=%0b busy=%0b want 1 0 1", c, res_valid, s_ready, busy);
        end
      end
      if (c == 35) begin
        tests++;
        if ({ld_en, reg_data} !== {1'b1, 8'hBB}) begin
          fails++;
          $display("FAIL bp_release got ld=%0b data=%h want 1 bb", ld_en, reg_data);
        end
      end
      if (c == 48) begin
        tests++;
        if (res_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_second_result got rv=%0b want 1", res_valid);
        end
      end
      if (c == 49) begin
        tests++;
        if ({busy, done_cnt} !== {1'b0, 16'd2}) begin
          fails++;
          $display("FAIL bp_no_third got busy=%0b cnt=%0d want 0 2", busy, done_cnt);
        end
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      s_valid = (c == 0) || (c == 2);
      s_data  = (c == 0) ? 8'h31 : 8'h32;
      @(negedge clk);
      if (c < 7) step();
    end
    tests++;
    if ({phase_en, phase, s_ready} !== {1'b1, 5'd5, 1'b0}) begin
      fails++;
      $display("FAIL mid_setup got pe=%0b ph=%0d rdy=%0b want 1 5 0", phase_en, phase, s_ready);
    end
    reset = 1'b1;
    s_valid = 1'b0;
    #1;
    tests++;
    if ({s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      fails++;
      $display("FAIL mid_reset_async got rdy=%0b ld=%0b pe=%0b ph=%0d rv=%0b busy=%0b cnt=%h data=%h want 1 0 0 0 0 0 0000 00",
               s_ready, ld_en, phase_en, phase, res_valid, busy, done_cnt, reg_data);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if ({res_valid, ld_en, busy, s_ready, phase_en} !== 5'b00010) begin
        fails++;
        $display("FAIL mid_after cycle %0d got rv=%0b ld=%0b busy=%0b rdy=%0b pe=%0b want 0 0 0 1 0",
                 k, res_valid, ld_en, busy, s_ready, phase_en);
      end
      step();
    end
  endtask

  task automatic test_wrap_done_accept;
    do_reset();
    force dut.done_count = 16'hFFFF;
    step();
    release dut.done_count;
    for (int c = 0; c < 30; c++) begin
      s_valid   = (c == 0) || (c == 14);
      s_data    = (c == 14) ? 8'h77 : 8'h44;
      res_ready = (c == 14) || (c == 28);
      @(negedge clk);
      if (c == 14) begin
        tests++;
        if ({res_valid, s_ready} !== 2'b11) begin
          fails++;
          $display("FAIL done_accept_ready got rv=%0b rdy=%0b want 1 1", res_valid, s_ready);
        end
      end
      if (c == 15) begin
        tests++;
        if ({ld_en, reg_data, done_cnt} !== {1'b1, 8'h77, 16'h0000}) begin
          fails++;
          $display("FAIL wrap_and_reload got ld=%0b data=%h cnt=%h want 1 77 0000", ld_en, reg_data, done_cnt);
        end
      end
      if (c == 29) begin
        tests++;
        if ({busy, done_cnt} !== {1'b0, 16'h0001}) begin
          fails++;
          $display("FAIL wrap_continue got busy=%0b cnt=%h want 0 0001", busy, done_cnt);
        end
      end
      step();
    end
    s_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_phases2;
    logic       ld_x, pe_x, rv_x, busy_x;
    logic [4:0] ph_x;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      s_valid2   = (c == 0);
      s_data2    = 8'h9C;
      res_ready2 = (c == 4);
      ld_x   = (c == 1);
      pe_x   = (c == 2) || (c == 3);
      ph_x   = (c == 3) ? 5'd1 : 5'd0;
      rv_x   = (c == 4);
      busy_x = (c >= 1) && (c <= 4);
      @(negedge clk);
      tests++;
      if ({ld_en2, phase_en2, phase2, res_valid2, busy2} !== {ld_x, pe_x, ph_x, rv_x, busy_x}) begin
        fails++;
        $display("FAIL p2 cycle %0d got ld=%0b pe=%0b ph=%0d rv=%0b busy=%0b want %0b %0b %0d %0b %0b",
                 c, ld_en2, phase_en2, phase2, res_valid2, busy2, ld_x, pe_x, ph_x, rv_x, busy_x);
      end
      if (c == 5) begin
        tests++;
        if ({done_cnt2, reg_data2} !== {16'd1, 8'h9C}) begin
          fails++;
          $display("FAIL p2_done got cnt=%0d data=%h want 1 9c", done_cnt2, reg_data2);
        end
      end
      step();
    end
    s_valid2 = 1'b0; res_ready2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap_done_accept();
    test_phases2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_seq_ctrl.md
SAMPLE_SEQ_CTRL -- requirements
Module: sample_seq_ctrl

Interface
REQ-001 Parameter: DW, 8, sample data width.
REQ-002 Parameter: PHASES, 12, number of encoder compute phases per sample; legal range 2..32.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: s_valid  in  1  upstream sample valid.
REQ-006 Port: s_ready  out  1  sample accepted when s_valid && s_ready.
REQ-007 Port: s_data  in  DW  upstream PCM sample.
REQ-008 Port: ld_en  out  1  one-cycle load strobe to the 8-bit input register.
REQ-009 Port: reg_data  out  DW  sample presented to the input register.
REQ-010 Port: phase  out  5  current compute phase index.
REQ-011 Port: phase_en  out  1  phase index valid; datapath executes that phase this cycle.
REQ-012 Port: res_valid  out  1  encoder result ready for downstream.
REQ-013 Port: res_ready  in  1  downstream accepts result when res_valid && res_ready.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.
REQ-015 Port: done_cnt  out  16  count of completed result handshakes.

Function
REQ-016 One-entry hold buffer (hold_data, hold_full); s_ready SHALL equal !hold_full, combinationally.
REQ-017 Accept SHALL write s_data into hold_data and set hold_full at the clock edge.
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-019 "Start" condition SHALL be hold_full || (s_valid && s_ready).
REQ-020 IDLE: start -> LOAD; otherwise stay IDLE.
REQ-021 LOAD (exactly one cycle): ld_en=1, reg_data takes hold_data this cycle, hold_full cleared at edge, phase counter cleared; -> RUN.
REQ-022 During LOAD, hold_full=1, so s_ready=0; no accept in LOAD.
REQ-023 RUN: phase_en=1, phase increments 0,1,..,PHASES-1 one per cycle; after phase PHASES-1 -> DONE.
REQ-024 Upstream accepts are permitted during RUN and DONE (buffer one sample ahead).
REQ-025 DONE: res_valid=1, held until res_valid && res_ready; no timeout.
REQ-026 DONE with handshake: start -> LOAD, else -> IDLE; done_cnt increments by 1 on that edge.
REQ-027 Accept in the same DONE cycle as the result handshake SHALL qualify as start (LOAD next cycle).
REQ-028 done_cnt SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-029 reg_data SHALL hold the last loaded value outside LOAD.
REQ-030 phase SHALL read 0 when phase_en=0.
REQ-031 Latency: accept in cycle T -> ld_en in T+1, phase_en in T+2..T+1+PHASES, res_valid first in T+2+PHASES.
REQ-032 Back-to-back throughput with res_ready=1 SHALL be one sample per PHASES+2 cycles.

Reset
REQ-033 On reset: state=IDLE, hold_full=0, hold_data=0, reg_data=0, phase counter=0, done_cnt=0.
REQ-034 Reset SHALL force outputs s_ready=1, ld_en=0, phase_en=0, phase=0, res_valid=0, busy=0.
REQ-035 Reset mid-operation (any state) SHALL discard the in-flight and held samples without producing res_valid.

Verification
REQ-036 Single sample, PHASES=12: s_data=0x5A accepted cycle 0 -> ld_en=1 and reg_data=0x5A in cycle 1, phase 0..11 in cycles 2..13, res_valid in cycle 14, done_cnt=1 after handshake.
REQ-037 Continuous s_valid, res_ready=1: second sample accepted in cycle 2 (first RUN cycle), ld_en for it in cycle 15, results every 14 cycles.
REQ-038 Backpressure: res_ready=0 for 20 cycles with a second sample held -> s_ready=0, res_valid stays 1, third sample not accepted; release -> LOAD next cycle.
REQ-039 Reset asserted in RUN phase 5 with hold_full=1 -> all outputs at reset values immediately, no res_valid after deassert, s_ready=1.
REQ-040 done_cnt preloaded via 65535 results -> next handshake yields done_cnt=0x0000.
REQ-041 PHASES=2 build: accept cycle 0 -> phase 0,1 in cycles 2,3, res_valid in cycle 4.
